// File: rtl/pixel_config_seq_if.sv
// Valid/ready word source feeding pixel_config_seq.
// master drives s_data/s_valid, slave returns s_ready.
interface pixel_config_seq_if #(
  parameter int DW = 6
);
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/pixel_config_seq.sv
// pixel_config chain loader: words in over s (slave), shifted on config_clk
// falls, push_en every row; ports busy/done/aborted/idx/err_cnt; opt CFG_READBACK_EN.
module pixel_config_seq #(
  parameter int DW            = 6,
  parameter int WORDS_PER_ROW = 32,
  parameter int ROWS          = 128,
  parameter int CLK_DIV       = 4,
  parameter int PUSH_CYC      = 4,
  localparam int WW =
    (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1,
  localparam int RW =
    (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk_40MHz,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  pixel_config_seq_if.slave s,
  output logic [DW-1:0] config_data,
  output logic          config_clk,
  output logic          config_en,
  output logic          push_en,
  input  logic          config_do,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [RW-1:0] row_idx,
  output logic [WW-1:0] word_idx,
  output logic [7:0]    err_cnt
);

  localparam int CMAX =
    (CLK_DIV > PUSH_CYC) ? CLK_DIV : PUSH_CYC;
  localparam int CW =
    (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SETUP,
    HIGH,
    PUSH,
    GAP,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          pend;
  logic          pend_nx;
  logic [WW-1:0] word_nx;
  logic [RW-1:0] row_nx;
  logic          en_nx;
  logic          load;
  logic          shift;
  logic          clr_err;
  logic          run;

  wire div_end  = (cnt == CW'(CLK_DIV - 1));
  wire push_end = (cnt == CW'(PUSH_CYC - 1));
  wire last_w   =
    (word_idx == WW'(WORDS_PER_ROW - 1));
  wire last_r   = (row_idx == RW'(ROWS - 1));

  assign run        = (state != IDLE) &&
                      (state != DONE);
  assign busy       = run;
  assign done       = (state == DONE);
  assign s.s_ready  = (state == WAIT_DATA);
  assign config_clk = (state == HIGH);
  assign push_en    = (state == PUSH);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend;
    word_nx  = word_idx;
    row_nx   = row_idx;
    en_nx    = config_en;
    load     = 1'b0;
    shift    = 1'b0;
    clr_err  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_nx = WAIT_DATA;
          word_nx  = '0;
          row_nx   = '0;
          pend_nx  = 1'b0;
          clr_err  = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (abort) begin
          state_nx = IDLE;
          en_nx    = 1'b0;
        end else if (s.s_valid) begin
          state_nx = SETUP;
          load     = 1'b1;
          en_nx    = 1'b1;
          cnt_nx   = '0;
        end
      end
      SETUP: begin
        if (abort) begin
          state_nx = IDLE;
          en_nx    = 1'b0;
        end else if (div_end) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HIGH: begin
        // abort here is deferred: the word
        // still shifts on the falling edge
        if (abort) pend_nx = 1'b1;
        if (div_end) begin
          cnt_nx = '0;
          shift  = 1'b1;
          if (abort || pend) begin
            state_nx = IDLE;
            en_nx    = 1'b0;
            pend_nx  = 1'b0;
          end else if (last_w) begin
            state_nx = PUSH;
            en_nx    = 1'b0;
          end else begin
            state_nx = WAIT_DATA;
            word_nx  = word_idx + WW'(1);
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      PUSH: begin
        if (abort) pend_nx = 1'b1;
        if (push_end) begin
          cnt_nx  = '0;
          word_nx = '0;
          if (abort || pend) begin
            state_nx = IDLE;
            pend_nx  = 1'b0;
          end else begin
            state_nx = GAP;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (last_r) begin
          state_nx = DONE;
        end else begin
          state_nx = WAIT_DATA;
          row_nx   = row_idx + RW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pend        <= 1'b0;
      word_idx    <= '0;
      row_idx     <= '0;
      config_en   <= 1'b0;
      config_data <= '0;
      aborted     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend      <= pend_nx;
      word_idx  <= word_nx;
      row_idx   <= row_nx;
      config_en <= en_nx;
      // only an abort takes a running
      // sequencer straight to IDLE
      aborted   <= run && (state_nx == IDLE);
      if (load) config_data <= s.s_data;
    end
  end

`ifdef CFG_READBACK_EN
  logic [3:0] hist;
  logic       chk;
  logic [7:0] err_q;

  // hist[3] is the MSB of the word shifted
  // three shifts before the latest one
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      chk   <= 1'b0;
      err_q <= '0;
    end else begin
      if (shift) begin
        hist <= {hist[2:0], config_data[DW-1]};
      end
      chk <= shift &&
             (32'(word_idx) >= 32'd3);
      if (clr_err) begin
        err_q <= '0;
      end else if (chk &&
                   (config_do != hist[3]) &&
                   (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign err_cnt = err_q;
`else
  logic unused_rb;
  assign unused_rb = ^{config_do, clr_err, shift};
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_pixel_config_seq.sv
// Bench for pixel_config_seq: vector table, hand-written
// abort/stall/reset sequences, random runs vs a source-order model.
module tb_pixel_config_seq;
  localparam int DW = 6;
  localparam int W  = 4;
  localparam int R  = 2;
  localparam int CD = 2;
  localparam int PC = 2;
`ifdef CFG_READBACK_EN
  localparam int EXP_ERR = 2;
`else
  localparam int EXP_ERR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic vld = 1'b0;
  logic config_do;
  logic [DW-1:0] config_data;
  logic config_clk, config_en, push_en;
  logic busy, done, aborted;
  logic [0:0] row_idx;
  logic [1:0] word_idx;
  logic [7:0] err_cnt;

  pixel_config_seq_if #(.DW(DW)) bus ();

  logic [DW-1:0] src [1024];
  int fed = 0;
  int cyc = 0;

  assign bus.s_valid = vld;
  assign bus.s_data  = src[fed & 1023];

  pixel_config_seq #(
    .DW(DW), .WORDS_PER_ROW(W), .ROWS(R),
    .CLK_DIV(CD), .PUSH_CYC(PC)
  ) dut (
    .clk_40MHz(clk), .rst_n(rst_n),
    .start(start), .abort(abort), .s(bus),
    .config_data(config_data),
    .config_clk(config_clk),
    .config_en(config_en), .push_en(push_en),
    .config_do(config_do), .busy(busy),
    .done(done), .aborted(aborted),
    .row_idx(row_idx), .word_idx(word_idx),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.s_valid && bus.s_ready) fed <= fed + 1;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               name, act, exp);
    end
  endtask

  // chain / bus monitor
  logic pclk = 1'b0, ppush = 1'b0;
  int falls = 0, pushes = 0, push_hi = 0;
  int hi_cnt = 0, run_base = 0, first_cyc = 0;
  bit idx_chk = 1'b0;
  logic force23 = 1'b0;
  logic [DW-1:0] shifted [$];
  int push_at [$];
  logic [DW-1:0] chain [4];

  assign config_do = force23 ? 1'b0 :
                     chain[3][DW-1];

  always @(negedge clk) begin
    int e;
    if (config_clk && push_en) begin
      nerr++;
      $display("FAIL clk_push_overlap: got 1 want 0");
    end
    if (config_clk) begin
      hi_cnt++;
      if (idx_chk) begin
        e = falls - run_base;
        check("idx", {row_idx, word_idx},
              (e / W) * 4 + (e % W));
      end
    end
    if (pclk && !config_clk) begin
      if (falls == run_base) first_cyc = cyc;
      falls++;
      shifted.push_back(config_data);
      chain[3] = chain[2];
      chain[2] = chain[1];
      chain[1] = chain[0];
      chain[0] = config_data;
    end
    if (push_en && !ppush) begin
      pushes++;
      push_at.push_back(falls - run_base);
    end
    if (push_en) push_hi++;
    pclk  = config_clk;
    ppush = push_en;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    vld   = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  int bf, bp, bh, sb, sbase;

  task automatic begin_run(input bit chk);
    bf = falls;
    bp = pushes;
    bh = push_hi;
    sb = shifted.size();
    sbase = fed;
    run_base = falls;
    push_at.delete();
    idx_chk = chk;
  endtask

  task automatic wait_done(input string t,
                           input int budget);
    for (int i = 0; i < budget && !done; i++)
      tick(1);
    check({t, "_done"}, done, 1);
  endtask

  task automatic end_checks(input string t);
    idx_chk = 1'b0;
    check({t, "_falls"}, falls - bf, W * R);
    check({t, "_pushes"}, pushes - bp, R);
    check({t, "_pushhi"}, push_hi - bh, R * PC);
    check({t, "_busy"}, busy, 0);
    check({t, "_npush"}, push_at.size(), R);
    for (int j = 0; j < push_at.size(); j++)
      check({t, "_pushpos"}, push_at[j],
            W * (j + 1));
    check({t, "_nshift"}, shifted.size() - sb,
          W * R);
    if (shifted.size() - sb == W * R)
      for (int j = 0; j < W * R; j++)
        check({t, "_word"}, shifted[sb + j],
              src[(sbase + j) & 1023]);
  endtask

  typedef struct {
    logic          start;
    logic          abort;
    logic          vld;
    logic [DW-1:0] d;
    logic [14:0]   exp;
  } vec_t;

  function automatic logic [14:0] mk(
    input logic r, c, e, p, b, dn, a,
    input logic [1:0] w, input logic [5:0] d);
    return {r, c, e, p, b, dn, a, w, d};
  endfunction

  vec_t tbl [12];
  logic [14:0] act;

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 want 1");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) src[i] = '0;
    for (int i = 0; i < 4; i++) chain[i] = '0;

    // per-cycle table: r c e p b dn a w data
    tbl[0]  = '{1, 0, 0, 6'h00,
      mk(1,0,0,0,1,0,0,2'd0,6'h00)};
    tbl[1]  = '{0, 0, 1, 6'h15,
      mk(0,0,1,0,1,0,0,2'd0,6'h15)};
    tbl[2]  = '{0, 0, 0, 6'h00,
      mk(0,0,1,0,1,0,0,2'd0,6'h15)};
    tbl[3]  = '{0, 0, 0, 6'h00,
      mk(0,1,1,0,1,0,0,2'd0,6'h15)};
    tbl[4]  = '{0, 0, 0, 6'h00,
      mk(0,1,1,0,1,0,0,2'd0,6'h15)};
    tbl[5]  = '{0, 0, 0, 6'h00,
      mk(1,0,1,0,1,0,0,2'd1,6'h15)};
    tbl[6]  = '{0, 0, 0, 6'h00,
      mk(1,0,1,0,1,0,0,2'd1,6'h15)};
    tbl[7]  = '{0, 1, 0, 6'h00,
      mk(0,0,0,0,0,0,1,2'd1,6'h15)};
    tbl[8]  = '{0, 0, 0, 6'h00,
      mk(0,0,0,0,0,0,0,2'd1,6'h15)};
    tbl[9]  = '{1, 1, 0, 6'h00,
      mk(0,0,0,0,0,0,0,2'd1,6'h15)};
    tbl[10] = '{1, 0, 0, 6'h00,
      mk(1,0,0,0,1,0,0,2'd0,6'h15)};
    tbl[11] = '{0, 1, 0, 6'h00,
      mk(0,0,0,0,0,0,1,2'd0,6'h15)};

    do_reset();
    check("reset_out",
      {bus.s_ready, config_clk, config_en, push_en,
       busy, done, aborted, config_data},
      0);
    check("reset_idx",
      {row_idx, word_idx, err_cnt}, 0);

    for (int i = 0; i < 12; i++) begin
      start = tbl[i].start;
      abort = tbl[i].abort;
      vld   = tbl[i].vld;
      src[fed & 1023] = tbl[i].d;
      tick(1);
      act = {bus.s_ready, config_clk, config_en,
             push_en, busy, done, aborted,
             word_idx, config_data};
      check($sformatf("vec%0d", i), act,
            tbl[i].exp);
    end
    start = 1'b0;
    abort = 1'b0;
    vld   = 1'b0;

    // 1: full run, valid always high
    do_reset();
    begin_run(1'b1);
    for (int i = 0; i < W * R; i++)
      src[(sbase + i) & 1023] = DW'(i + 1);
    vld = 1'b1;
    bf = cyc;
    pulse_start();
    wait_done("t1", 300);
    check("t1_lat", first_cyc - bf, 2 * CD + 2);
    bf = falls - W * R;
    end_checks("t1");

    // 2: stall mid-row
    begin_run(1'b0);
    for (int i = 0; i < W * R; i++)
      src[(sbase + i) & 1023] = DW'(8'h20 + i);
    vld = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 &&
         falls - run_base < 2; i++)
      tick(1);
    vld = 1'b0;
    begin
      int f0, h0;
      f0 = falls;
      h0 = hi_cnt;
      tick(10);
      check("t2_falls", falls, f0);
      check("t2_high", hi_cnt, h0);
      check("t2_widx", word_idx, 2);
      check("t2_ready", bus.s_ready, 1);
    end
    vld = 1'b1;
    wait_done("t2", 300);
    end_checks("t2");

    // 3: abort in SETUP of word 2
    begin_run(1'b0);
    vld = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 &&
         !(falls - run_base == 1 && busy &&
           !bus.s_ready && !config_clk); i++)
      tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t3_state",
      {busy, aborted, done, config_en, config_clk},
      5'b01000);
    tick(4);
    check("t3_falls", falls - run_base, 1);
    check("t3_after", {busy, aborted, done}, 0);

    // 4: abort in HIGH of word 3
    begin_run(1'b0);
    vld = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 &&
         !(falls - run_base == 2 && config_clk); i++)
      tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t4_hold",
      {busy, config_clk, aborted}, 3'b110);
    tick(1);
    check("t4_falls", falls - run_base, 3);
    check("t4_state", {busy, aborted, done},
          3'b010);
    tick(3);
    check("t4_nopush", push_hi - bh, 0);

    // abort in PUSH finishes the pulse
    begin_run(1'b0);
    vld = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 && !push_en; i++)
      tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("tp_hold", {push_en, busy}, 2'b11);
    tick(1);
    check("tp_state",
      {push_en, busy, aborted}, 3'b001);
    check("tp_pushhi", push_hi - bh, PC);

    // 5: reset during PUSH, then replay
    begin_run(1'b0);
    vld = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 && !push_en; i++)
      tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst",
      {push_en, config_en, config_clk, busy,
       bus.s_ready, done, aborted},
      0);
    check("t5_rst_reg",
      {config_data, row_idx, word_idx, err_cnt},
      0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    begin_run(1'b1);
    for (int i = 0; i < W * R; i++)
      src[(sbase + i) & 1023] = DW'(8'h30 + i);
    pulse_start();
    wait_done("t5", 300);
    end_checks("t5");

    // 6: chain with stuck oldest bit
    force23 = 1'b1;
    begin_run(1'b0);
    for (int i = 0; i < W * R; i++)
      src[(sbase + i) & 1023] = 6'h3F;
    pulse_start();
    wait_done("t6", 300);
    check("t6_err", err_cnt, EXP_ERR);
    force23 = 1'b0;

    // random runs against the source order
    for (int r = 0; r < 3; r++) begin
      begin_run(1'b1);
      for (int i = 0; i < W * R; i++)
        src[(sbase + i) & 1023] =
          DW'($urandom_range(0, 63));
      vld = 1'b0;
      pulse_start();
      check("rnd_errclr", err_cnt, 0);
      for (int i = 0; i < 600 && !done; i++) begin
        vld = ($urandom_range(0, 3) != 0);
        tick(1);
      end
      check("rnd_done", done, 1);
      end_checks($sformatf("rnd%0d", r));
      check("rnd_err", err_cnt, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
